dlx_regfile_sb: RTL and testbench
=================================

Name: dlx_regfile_sb

Overview:
Parametrised DLX integer register file with N read ports, one write port and write-to-read bypass. An integrated scoreboard tracks registers with an in-flight write.
Sits between decode (operand read, hazard check, issue) and writeback.
Replaces the fixed 2-read, 32x32 register file. Adds full reset, same-cycle bypass and busy tracking for stall generation.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of read ports (1..4)
AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
rd_en  in  NRD  per-port read enable
rs_addr  in  NRD x AW  per-port source register number
rs_data  out  NRD x XLEN  per-port registered read data
rs_busy  out  NRD  per-port combinational: source has pending write
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback value
iss_en  in  1  instruction issued with a destination register
iss_addr  in  AW  destination of issued instruction
any_busy  out  1  OR of all busy bits (drain/flush monitoring)

Behaviour:
- Reset, asynchronous, reset_n=0:
  - all NREGS registers = 0
  - all busy bits = 0
  - rs_data = 0, rs_busy = 0, any_busy = 0
  - state is held while reset_n=0
- Register 0:
  - always reads 0
  - writes to it are ignored
  - never busy: iss_en with iss_addr=0 has no effect
- Read:
  - 1-cycle latency: rd_en[i]=1 at edge k puts the value of rs_addr[i] on rs_data[i] after edge k.
  - rd_en[i]=0: rs_data[i] holds its previous value.
  - Ports are independent; the same address on several ports is legal.
- Write: wr_en=1 and wr_addr!=0 updates regs[wr_addr] at the edge.
- Bypass: if in the same cycle rd_en[i], wr_en, rs_addr[i]==wr_addr and wr_addr!=0, then rs_data[i] takes wr_data (new value, not old).
- Scoreboard, one busy bit per register:
  - iss_en sets busy[iss_addr].
  - wr_en clears busy[wr_addr].
  - Same register set and cleared in the same cycle: set wins (a new producer replaces the old).
  - Set and clear on different registers in the same cycle: both take effect.
  - iss_en on an already-busy register: stays busy. No counting; the pipeline guarantees in-order writeback per register.
  - wr_en on a non-busy register: the write is performed and the bit stays 0.
- rs_busy[i] = busy[rs_addr[i]] & ~(wr_en & wr_addr==rs_addr[i]) & ~iss-set.
  - The current-cycle writeback is visible to hazard logic immediately (bypass covers the data).
  - A same-cycle iss_en does NOT raise rs_busy; the issuing instruction never depends on itself.
  - rs_addr[i]==0 gives rs_busy[i]=0.
- any_busy is registered from the busy vector (reflects state after the edge).
- Out-of-range addresses cannot occur (NREGS is a power of 2).

Decomposition:
- Package dlx_regfile_pkg:
  - XLEN default
  - NREGS default
  - reg_addr_t (logic [AW-1:0])
  - word_t (logic [XLEN-1:0])
  - constant REG_ZERO = 0
- Sub-module dlx_scoreboard (params NREGS):
  - inputs: iss_en/iss_addr, wr_en/wr_addr, query addresses
  - outputs: per-query busy, any_busy
  - owns the busy vector and its set-wins rule
- Storage array, read ports and bypass stay in the top level.

Test Plan:
- Reset mid-run: write r5=0xDEADBEEF, assert reset_n=0 between edges -> rs_data=0 immediately; after release, read r5 -> 0x00000000.
- Write r0=0x1234 then read r0 on both ports -> 0x00000000; iss_en r0 -> rs_busy stays 0, any_busy=0.
- Bypass: same cycle wr_en r7=0xA5A5A5A5 and rd_en port1 r7 (old value 0x11) -> port1 rs_data=0xA5A5A5A5 next cycle; port0 reading r8 unaffected.
- Scoreboard: iss r3 at cycle 1 -> rs_busy=1 for r3 at cycles 2..; wr r3=0x42 at cycle 4 -> rs_busy=0 during cycle 4 and read returns 0x42.
- Simultaneous iss r9 and wr r9=0x77 -> regs[9]=0x77 and busy[9]=1 afterwards; later wr r9 clears it.
- Hold: read r2=0x55, then rd_en=0 while writing r2=0x66 -> rs_data stays 0x55 until the next rd_en.

Source files
------------

// File: rtl/dlx_regfile_pkg.sv
// Shared types and defaults for the DLX register file with scoreboard.
// Parametrised modules derive their own widths; the typedefs fix the default configuration.
package dlx_regfile_pkg;

  localparam int DLX_XLEN  = 32;
  localparam int DLX_NREGS = 32;
  localparam int DLX_AW    = $clog2(DLX_NREGS);

  typedef logic [DLX_AW-1:0]   reg_addr_t;
  typedef logic [DLX_XLEN-1:0] word_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/dlx_regfile_sb_if.sv
// Decode/writeback side bus of the register file: read ports, writeback, issue and busy status.
interface dlx_regfile_sb_if
  import dlx_regfile_pkg::*;
#(
  parameter int XLEN  = DLX_XLEN,
  parameter int NREGS = DLX_NREGS,
  parameter int NRD   = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0]           rd_en;
  logic [NRD-1:0][AW-1:0]   rs_addr;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     any_busy;

  modport master (
    output rd_en, rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rs_data, rs_busy, any_busy
  );

  modport slave (
    input  rd_en, rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rs_data, rs_busy, any_busy
  );

endinterface

// File: rtl/dlx_scoreboard.sv
// One busy bit per architectural register; set by issue, cleared by writeback, set wins.
// Query outputs are combinational and already account for the current-cycle writeback and issue.
module dlx_scoreboard
  import dlx_regfile_pkg::*;
#(
  parameter  int NREGS = DLX_NREGS,
  parameter  int NQ    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NQ-1:0][AW-1:0] q_addr,
  output logic [NQ-1:0]        q_busy,
  output logic                 any_busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             any_busy_q, any_busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    // Applied after the clear so a new producer replaces the retiring one.
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
    any_busy_d = |busy_d;
  end

  always_comb begin
    q_busy = '0;
    for (int i = 0; i < NQ; i++) begin
      q_busy[i] = busy_q[q_addr[i]]
                & ~(wr_en  && (wr_addr  == q_addr[i]))
                & ~(iss_en && (iss_addr == q_addr[i]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign any_busy = any_busy_q;

endmodule

// File: rtl/dlx_regfile_sb.sv
// DLX integer register file: NRD registered read ports, one write port with same-cycle bypass,
// and a scoreboard flagging sources whose producer has issued but not yet written back.
module dlx_regfile_sb
  import dlx_regfile_pkg::*;
#(
  parameter int XLEN  = DLX_XLEN,
  parameter int NREGS = DLX_NREGS,
  parameter int NRD   = 2
) (
  input logic                clk,
  input logic                reset_n,
  dlx_regfile_sb_if.slave    bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]          regs_q [NREGS];
  logic [XLEN-1:0]          regs_d [NREGS];
  logic [NRD-1:0][XLEN-1:0] rs_data_q, rs_data_d;
  logic                     wr_live;
  logic [NRD-1:0]           rs_busy;
  logic                     any_busy;

  always_comb begin
    wr_live = bus.wr_en && (bus.wr_addr != AW'(REG_ZERO));
    regs_d  = regs_q;
    if (wr_live) regs_d[bus.wr_addr] = bus.wr_data;

    rs_data_d = rs_data_q;
    for (int i = 0; i < NRD; i++) begin
      if (bus.rd_en[i]) begin
        // Bypass: a reader in the writeback cycle sees the new value, not the stale entry.
        if (wr_live && (bus.wr_addr == bus.rs_addr[i])) rs_data_d[i] = bus.wr_data;
        else                                          rs_data_d[i] = regs_q[bus.rs_addr[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      rs_data_q <= '0;
    end else begin
      regs_q    <= regs_d;
      rs_data_q <= rs_data_d;
    end
  end

  dlx_scoreboard #(
    .NREGS (NREGS),
    .NQ    (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .q_addr   (bus.rs_addr),
    .q_busy   (rs_busy),
    .any_busy (any_busy)
  );

  assign bus.rs_data  = rs_data_q;
  assign bus.rs_busy  = rs_busy;
  assign bus.any_busy = any_busy;

endmodule

// File: tb/tb_dlx_regfile_sb.sv
// Bench for dlx_regfile_sb: directed scenarios plus random traffic against an array-based model.
module tb_dlx_regfile_sb;
  import dlx_regfile_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  dlx_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

  dlx_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers, busy set, last value seen per port.
  word_t       m_regs [32];
  logic [31:0] m_busy;
  word_t       m_rd [2];
  logic        m_any;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_any = 1'b0;
  endtask

  task automatic drive(input logic [1:0] rd, input int a0, input int a1,
                       input logic we, input int wa, input word_t wd,
                       input logic ie, input int ia);
    bus.rd_en      = rd;
    bus.rs_addr[0] = 5'(a0);
    bus.rs_addr[1] = 5'(a1);
    bus.wr_en      = we;
    bus.wr_addr    = 5'(wa);
    bus.wr_data    = wd;
    bus.iss_en     = ie;
    bus.iss_addr   = 5'(ia);
    #1;
  endtask

  function automatic logic exp_busy(int i);
    int a;
    a = int'(bus.rs_addr[i]);
    return (a != 0) && m_busy[a]
        && !(bus.wr_en  && int'(bus.wr_addr)  == a)
        && !(bus.iss_en && int'(bus.iss_addr) == a);
  endfunction

  // Advance one clock, applying the architectural rules to the model from the driven inputs.
  task automatic tick();
    word_t nd [2];
    int    a, wa, ia;
    wa = int'(bus.wr_addr);
    ia = int'(bus.iss_addr);
    for (int i = 0; i < 2; i++) begin
      a = int'(bus.rs_addr[i]);
      if (!bus.rd_en[i])                          nd[i] = m_rd[i];
      else if (bus.wr_en && wa == a && a != 0)    nd[i] = bus.wr_data;
      else                                        nd[i] = m_regs[a];
    end
    if (bus.wr_en && wa != 0) m_regs[wa] = bus.wr_data;
    if (bus.wr_en) m_busy[wa] = 1'b0;
    if (bus.iss_en && ia != 0) m_busy[ia] = 1'b1;
    m_rd[0] = nd[0];
    m_rd[1] = nd[1];
    m_any = |m_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int a0, input int a1);
    drive(2'b00, a0, a1, 1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.rs_data[0] !== 32'h0 || bus.rs_data[1] !== 32'h0) begin
      errors++; $display("FAIL reset_rs_data: got %h %h expected 0 0", bus.rs_data[0], bus.rs_data[1]);
    end
    checks++;
    if (bus.rs_busy !== 2'b00 || bus.any_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got rs_busy=%b any=%b expected 00 0", bus.rs_busy, bus.any_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    drive(2'b00, 0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b1, 6);
    tick();
    drive(2'b01, 5, 0, 1'b0, 0, '0, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'hDEADBEEF || bus.any_busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got %h any=%b expected deadbeef 1", bus.rs_data[0], bus.any_busy);
    end
    idle(5, 6);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rs_data[0] !== 32'h0 || bus.any_busy !== 1'b0 || bus.rs_busy !== 2'b00) begin
      errors++; $display("FAIL midreset_async: got %h any=%b busy=%b expected 0 0 00",
                         bus.rs_data[0], bus.any_busy, bus.rs_busy);
    end
    model_reset();
    drive(2'b11, 5, 6, 1'b1, 5, 32'h1, 1'b1, 7);
    @(posedge clk);
    #1;
    checks++;
    if (bus.rs_data[0] !== 32'h0 || bus.any_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_hold: got %h any=%b expected 0 0", bus.rs_data[0], bus.any_busy);
    end
    idle(5, 6);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b01, 5, 0, 1'b0, 0, '0, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h0) begin
      errors++; $display("FAIL midreset_r5: got %h expected 00000000", bus.rs_data[0]);
    end
  endtask

  task automatic test_reg_zero();
    drive(2'b00, 0, 0, 1'b1, 4, 32'h4444, 1'b0, 0);
    tick();
    drive(2'b11, 4, 4, 1'b0, 0, '0, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h4444 || bus.rs_data[1] !== 32'h4444) begin
      errors++; $display("FAIL r0_pre: got %h %h expected 4444 4444", bus.rs_data[0], bus.rs_data[1]);
    end
    drive(2'b00, 0, 0, 1'b1, 0, 32'h1234, 1'b0, 0);
    tick();
    drive(2'b11, 0, 0, 1'b1, 0, 32'h5678, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h0 || bus.rs_data[1] !== 32'h0) begin
      errors++; $display("FAIL r0_read: got %h %h expected 0 0", bus.rs_data[0], bus.rs_data[1]);
    end
    drive(2'b00, 0, 0, 1'b0, 0, '0, 1'b1, 0);
    checks++;
    if (bus.rs_busy !== 2'b00) begin
      errors++; $display("FAIL r0_iss_busy: got %b expected 00", bus.rs_busy);
    end
    tick();
    idle(0, 0);
    checks++;
    if (bus.any_busy !== 1'b0 || bus.rs_busy !== 2'b00) begin
      errors++; $display("FAIL r0_after_iss: got any=%b busy=%b expected 0 00", bus.any_busy, bus.rs_busy);
    end
  endtask

  task automatic test_bypass();
    drive(2'b00, 0, 0, 1'b1, 7, 32'h11, 1'b0, 0);
    tick();
    drive(2'b00, 0, 0, 1'b1, 8, 32'h88, 1'b0, 0);
    tick();
    drive(2'b11, 8, 7, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[1] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_port1: got %h expected a5a5a5a5", bus.rs_data[1]);
    end
    checks++;
    if (bus.rs_data[0] !== 32'h88) begin
      errors++; $display("FAIL bypass_port0: got %h expected 00000088", bus.rs_data[0]);
    end
  endtask

  task automatic test_scoreboard();
    drive(2'b01, 3, 0, 1'b0, 0, '0, 1'b1, 3);
    checks++;
    if (bus.rs_busy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_same_cycle_iss: got %b expected 0", bus.rs_busy[0]);
    end
    tick();
    checks++;
    if (bus.any_busy !== 1'b1) begin
      errors++; $display("FAIL sb_any_set: got %b expected 1", bus.any_busy);
    end
    for (int c = 0; c < 2; c++) begin
      idle(3, 3);
      checks++;
      if (bus.rs_busy !== 2'b11) begin
        errors++; $display("FAIL sb_pending: cycle %0d got %b expected 11", c, bus.rs_busy);
      end
      tick();
    end
    drive(2'b01, 3, 0, 1'b1, 3, 32'h42, 1'b0, 0);
    checks++;
    if (bus.rs_busy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_wb_cycle: got %b expected 0", bus.rs_busy[0]);
    end
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h42 || bus.any_busy !== 1'b0) begin
      errors++; $display("FAIL sb_wb_read: got %h any=%b expected 42 0", bus.rs_data[0], bus.any_busy);
    end
  endtask

  task automatic test_set_wins();
    drive(2'b10, 0, 9, 1'b1, 9, 32'h77, 1'b1, 9);
    checks++;
    if (bus.rs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL setwins_cycle: got %b expected 0", bus.rs_busy[1]);
    end
    tick();
    idle(0, 9);
    checks++;
    if (bus.rs_data[1] !== 32'h77 || bus.rs_busy[1] !== 1'b1 || bus.any_busy !== 1'b1) begin
      errors++; $display("FAIL setwins_after: got %h busy=%b any=%b expected 77 1 1",
                         bus.rs_data[1], bus.rs_busy[1], bus.any_busy);
    end
    drive(2'b00, 0, 9, 1'b1, 9, 32'h78, 1'b0, 0);
    tick();
    drive(2'b10, 0, 9, 1'b0, 0, '0, 1'b0, 0);
    checks++;
    if (bus.rs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL setwins_clear: got %b expected 0", bus.rs_busy[1]);
    end
    tick();
    checks++;
    if (bus.rs_data[1] !== 32'h78 || bus.any_busy !== 1'b0) begin
      errors++; $display("FAIL setwins_final: got %h any=%b expected 78 0", bus.rs_data[1], bus.any_busy);
    end
  endtask

  task automatic test_hold();
    drive(2'b00, 0, 0, 1'b1, 2, 32'h55, 1'b0, 0);
    tick();
    drive(2'b01, 2, 0, 1'b0, 0, '0, 1'b0, 0);
    tick();
    drive(2'b00, 2, 0, 1'b1, 2, 32'h66, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h55) begin
      errors++; $display("FAIL hold_wr: got %h expected 55", bus.rs_data[0]);
    end
    idle(2, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h55) begin
      errors++; $display("FAIL hold_idle: got %h expected 55", bus.rs_data[0]);
    end
    drive(2'b01, 2, 0, 1'b0, 0, '0, 1'b0, 0);
    tick();
    checks++;
    if (bus.rs_data[0] !== 32'h66) begin
      errors++; $display("FAIL hold_reread: got %h expected 66", bus.rs_data[0]);
    end
  endtask

  task automatic test_random();
    int a0, a1, wa, ia;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        a0 = $urandom_range(0, 7); a1 = $urandom_range(0, 7);
        wa = $urandom_range(0, 7); ia = $urandom_range(0, 7);
      end else begin
        a0 = $urandom_range(0, 31); a1 = $urandom_range(0, 31);
        wa = $urandom_range(0, 31); ia = $urandom_range(0, 31);
      end
      drive(2'($urandom_range(0, 3)), a0, a1, 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 2) == 0), ia);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bus.rs_busy[i] !== exp_busy(i)) begin
          errors++; $display("FAIL rnd_busy[%0d] @%0d: got %b expected %b", i, n, bus.rs_busy[i], exp_busy(i));
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bus.rs_data[i] !== m_rd[i]) begin
          errors++; $display("FAIL rnd_data[%0d] @%0d: got %h expected %h", i, n, bus.rs_data[i], m_rd[i]);
        end
      end
      checks++;
      if (bus.any_busy !== m_any) begin
        errors++; $display("FAIL rnd_any @%0d: got %b expected %b", n, bus.any_busy, m_any);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mid_reset();
    test_reg_zero();
    test_bypass();
    test_scoreboard();
    test_set_wins();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
